sms32_38_inv_seq: RTL and testbench



---
 rtl/sms32_38_inv_seq.sv | 214 +++++++++++++++++++++
 tb/tb_sms32_38_inv_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sms32_38_inv_seq.sv
// sms32_38_inv_seq: multi-cycle inverse of the 6-bit SMS32_38 power S-box.
//   y = x^5 in GF(2^6) (field polynomial t^6+t^5+t^3+t^2+1). Because
//   38*5 = 1 mod 63, y is the preimage of x under the forward x^38 S-box.
//   Arithmetic runs in the tower field GF((2^3)^2):
//     GF(2^3) = GF(2)[z]/(z^3+z+1),  GF(2^6) = GF(2^3)[Y]/(Y^2+Y+L), L = z+1.
//   The isomorphism maps the polynomial-basis root t to the tower element Y.
//   One shared tower multiplier is reused over SQ1 (w^2), SQ2 (w^4), MUL (w^5).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   x presented          in_ready   block can accept x (IDLE)
//   x          S-box input, polynomial basis
//   out_valid  y valid              out_ready  consumer accepts y
//   y          x^5, polynomial basis
//   busy       high in SQ1, SQ2, MUL
//   chk_err    (SMS32_INV_ERRCHK_EN only) sticky: forward S-box of y != x
//
// Optional feature macro: SMS32_INV_ERRCHK_EN
module sms32_38_inv_seq #(
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y,
    output logic              busy
`ifdef SMS32_INV_ERRCHK_EN
    ,
    output logic              chk_err
`endif
);

    generate
        if (DATA_W != 6) begin : g_bad_width
            $error("sms32_38_inv_seq: DATA_W must be 6");
        end
    endgenerate

    // ---------------- GF(2^3) primitives ----------------
    function automatic logic [2:0] gf8_add(input logic [2:0] a, input logic [2:0] b);
        return a ^ b;
    endfunction

    function automatic logic [2:0] gf8_mul(input logic [2:0] a, input logic [2:0] b);
        logic [4:0] p;
        p[0] = a[0] & b[0];
        p[1] = (a[0] & b[1]) ^ (a[1] & b[0]);
        p[2] = (a[0] & b[2]) ^ (a[1] & b[1]) ^ (a[2] & b[0]);
        p[3] = (a[1] & b[2]) ^ (a[2] & b[1]);
        p[4] = a[2] & b[2];
        // z^3 = z+1, z^4 = z^2+z
        return {p[2] ^ p[4], p[1] ^ p[3] ^ p[4], p[0] ^ p[3]};
    endfunction

    // multiply by the tower constant L = z+1
    function automatic logic [2:0] gf8_mul_l(input logic [2:0] a);
        return {a[2] ^ a[1], a[2] ^ a[1] ^ a[0], a[2] ^ a[0]};
    endfunction

    // ---------------- GF((2^3)^2) multiplier ----------------
    // Element = hi*Y + lo. Karatsuba form: three GF(2^3) products.
    function automatic logic [5:0] gf64_mul(input logic [5:0] a, input logic [5:0] b);
        logic [2:0] hh, ll, mm;
        hh = gf8_mul(a[5:3], b[5:3]);
        ll = gf8_mul(a[2:0], b[2:0]);
        mm = gf8_mul(gf8_add(a[5:3], a[2:0]), gf8_add(b[5:3], b[2:0]));
        return {gf8_add(mm, ll), gf8_add(gf8_mul_l(hh), ll)};
    endfunction

    // polynomial basis -> tower basis (column i holds Y^i)
    function automatic logic [5:0] iso(input logic [5:0] a);
        logic [5:0] r;
        r[0] = a[0] ^ a[2] ^ a[3] ^ a[5];
        r[1] = a[2] ^ a[3] ^ a[4] ^ a[5];
        r[2] = a[4];
        r[3] = a[1] ^ a[2] ^ a[4] ^ a[5];
        r[4] = a[3] ^ a[5];
        r[5] = a[5];
        return r;
    endfunction

    // tower basis -> polynomial basis
    function automatic logic [5:0] inv_iso(input logic [5:0] t);
        logic [5:0] r;
        r[0] = t[0] ^ t[1] ^ t[2];
        r[1] = t[1] ^ t[3] ^ t[4] ^ t[5];
        r[2] = t[1] ^ t[2] ^ t[4];
        r[3] = t[4] ^ t[5];
        r[4] = t[2];
        r[5] = t[5];
        return r;
    endfunction

    // ---------------- control ----------------
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQ1  = 3'd1,
        SQ2  = 3'd2,
        MUL  = 3'd3,
        DONE = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  w_q, w_d;
    logic [5:0]  t_q, t_d;
    logic [5:0]  y_q, y_d;
    logic        ov_q, ov_d;
    logic [5:0]  op_a, op_b, prod;

    // shared multiplier operand select
    always_comb begin
        op_a = w_q;
        op_b = w_q;
        case (state_q)
            SQ2: begin op_a = t_q; op_b = t_q; end
            MUL: begin op_a = t_q; op_b = w_q; end
            default: ;
        endcase
        prod = gf64_mul(op_a, op_b);
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        t_d     = t_q;
        y_d     = y_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: if (in_valid) begin
                w_d     = iso(x);
                state_d = SQ1;
            end
            SQ1: begin
                t_d     = prod;
                state_d = SQ2;
            end
            SQ2: begin
                t_d     = prod;
                state_d = MUL;
            end
            MUL: begin
                y_d     = inv_iso(prod);
                ov_d    = 1'b1;
                state_d = DONE;
            end
            DONE: if (out_ready) begin
                ov_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            t_q     <= '0;
            y_q     <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            t_q     <= t_d;
            y_q     <= y_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SQ1) || (state_q == SQ2) || (state_q == MUL);
    assign out_valid = ov_q;
    assign y         = y_q;

`ifdef SMS32_INV_ERRCHK_EN
    // The original operand is only needed to check the result, so it is
    // captured only when the checker exists.
    function automatic logic [5:0] gf64_pow38(input logic [5:0] a);
        logic [5:0] s2, s4, s8, s16, s32;
        s2  = gf64_mul(a, a);
        s4  = gf64_mul(s2, s2);
        s8  = gf64_mul(s4, s4);
        s16 = gf64_mul(s8, s8);
        s32 = gf64_mul(s16, s16);
        return gf64_mul(gf64_mul(s32, s4), s2);
    endfunction

    logic [5:0] x_q;
    logic [5:0] fwd;
    logic       chk_err_q;

    always_comb fwd = inv_iso(gf64_pow38(iso(y_q)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q       <= '0;
            chk_err_q <= 1'b0;
        end else begin
            if (state_q == IDLE && in_valid)
                x_q <= x;
            if (state_q == DONE && fwd != x_q)
                chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_sms32_38_inv_seq.sv
module tb_sms32_38_inv_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] x = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] y;
    logic       busy;
`ifdef SMS32_INV_ERRCHK_EN
    logic       chk_err;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    sms32_38_inv_seq #(.DATA_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
`ifdef SMS32_INV_ERRCHK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain polynomial-basis arithmetic mod t^6+t^5+t^3+t^2+1.
    function automatic logic [5:0] gmul(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] aa;
        logic [5:0] r;
        r  = '0;
        aa = {1'b0, a};
        for (int i = 0; i < 6; i++) begin
            if (b[i]) r = r ^ aa[5:0];
            aa = aa << 1;
            if (aa[6]) aa = aa ^ 7'h6D;
        end
        return r;
    endfunction

    function automatic logic [5:0] gpow(input logic [5:0] a, input int e);
        logic [5:0] r;
        r = 6'd1;
        for (int i = 0; i < e; i++) r = gmul(r, a);
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Starts at a negedge in IDLE; ends at the negedge after the output handshake.
    task automatic run_one(input logic [5:0] xv, input int stall,
                           output logic [5:0] yv, output int acc);
        int lat, bcnt;
        bit rdy_seen, got;
        chk("idle_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        x         = xv;
        out_ready = (stall == 0);
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
        x        = 6'($urandom);
        lat = 0; bcnt = 0; rdy_seen = 0; got = 0;
        while (lat < 20 && !got) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (in_ready) rdy_seen = 1;
            if (out_valid) got = 1;
        end
        chk("latency", lat, 4);
        chk("busy_cycles", bcnt, 3);
        chk("in_ready_low", int'(rdy_seen), 0);
        yv = y;
        if (stall > 0) begin
            out_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk);
                @(negedge clk);
                chk("stall_y", y, yv);
                chk("stall_valid", out_valid, 1);
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("post_hs_valid", out_valid, 0);
        chk("post_hs_ready", in_ready, 1);
    endtask

    typedef struct {
        logic [5:0] x;
        logic [5:0] y;
    } vec_t;

    vec_t       tbl[6];
    logic [5:0] yv, xb, perm[64];
    int         acc, prev_acc, lat;
    bit         seen[64];
    bit         stale;

    initial begin
        tbl[0] = '{6'h00, 6'h00};
        tbl[1] = '{6'h01, 6'h01};
        tbl[2] = '{6'h02, 6'h20};
        tbl[3] = '{6'h04, 6'h0C};
        tbl[4] = '{6'h08, 6'h34};
        tbl[5] = '{6'h03, 6'h33};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_y", y, 0);
`ifdef SMS32_INV_ERRCHK_EN
        chk("rst_chk_err", chk_err, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // fixed vectors
        for (int i = 0; i < 6; i++) begin
            run_one(tbl[i].x, 0, yv, acc);
            chk($sformatf("tbl_y_%0h", tbl[i].x), yv, tbl[i].y);
        end

        // all 64 inputs back to back, random order
        for (int i = 0; i < 64; i++) begin perm[i] = 6'(i); seen[i] = 0; end
        for (int i = 63; i > 0; i--) begin
            int j;
            logic [5:0] tmp;
            j = $urandom_range(0, i);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        prev_acc = 0;
        for (int i = 0; i < 64; i++) begin
            run_one(perm[i], 0, yv, acc);
            chk("all_y", yv, gpow(perm[i], 5));
            chk("all_fwd", gpow(yv, 38), perm[i]);
            chk("all_distinct", int'(seen[yv]), 0);
            seen[yv] = 1;
            if (i > 0) chk("accept_spacing", acc - prev_acc, 5);
            prev_acc = acc;
        end

        // random operands with random output back-pressure
        for (int i = 0; i < 20; i++) begin
            xb = 6'($urandom);
            run_one(xb, $urandom_range(0, 3), yv, acc);
            chk("rand_y", yv, gpow(xb, 5));
        end

        // long stall with a competing input held valid
        in_valid = 1'b1; x = 6'h2A; out_ready = 1'b0;
        @(posedge clk); #1;
        x = 6'h15;
        repeat (4) @(negedge clk);
        yv = y;
        chk("stall_first_y", yv, gpow(6'h2A, 5));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_y", y, yv);
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_ready", in_ready, 1);
        chk("release_valid", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 20 && !out_valid) begin @(negedge clk); lat++; end
        chk("second_latency", lat, 4);
        chk("second_y", y, gpow(6'h15, 5));
        @(posedge clk);
        @(negedge clk);

        // reset during SQ2 aborts the computation
        in_valid = 1'b1; x = 6'h27;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_ready", in_ready, 1);
        chk("abort_valid", out_valid, 0);
        chk("abort_y", y, 0);
        chk("abort_busy", busy, 0);
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || busy) stale = 1;
        end
        chk("abort_no_stale", int'(stale), 0);
        run_one(6'h27, 1, yv, acc);
        chk("abort_recover_y", yv, gpow(6'h27, 5));

`ifdef SMS32_INV_ERRCHK_EN
        begin
            logic [5:0] tv;
            chk("errchk_clean", chk_err, 0);
            in_valid = 1'b1; x = 6'h05; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            tv = dut.t_q;
            force dut.t_q = tv ^ 6'd1;
            @(posedge clk); #1;
            release dut.t_q;
            lat = 0;
            while (lat < 20 && !out_valid) begin @(negedge clk); lat++; end
            chk("errchk_before", chk_err, 0);
            @(posedge clk);
            @(negedge clk);
            chk("errchk_set", chk_err, 1);
            run_one(6'h09, 0, yv, acc);
            chk("errchk_sticky", chk_err, 1);
            rst_n = 1'b0;
            @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            chk("errchk_cleared", chk_err, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
